tone_detect: RTL and testbench

TONE_DETECT -- requirements
Module: tone_detect

---
 rtl/tone_detect_pkg.sv | 31 +++
 rtl/tone_edge_sync.sv | 43 ++++
 rtl/tone_detect.sv | 133 +++++++++++++
 tb/tb_tone_detect.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tone_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tone_detect_pkg
// Brief    : Shared widths, parameter defaults and FSM state encoding for
//            the tone half-period detector.
// Revision : 1.0 - initial release
// ============================================================================
package tone_detect_pkg;

    localparam int c_val_w           = 15;
    localparam int c_cnt_w           = 16;
    localparam int c_tol_default     = 2;
    localparam int c_timeout_default = 32767;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_MEAS  = 2'd2,
        ST_LOCK  = 2'd3
    } state_t;

    // Unsigned magnitude of a-b without wrap-around.
    function automatic logic [c_cnt_w-1:0] abs_diff(
        input logic [c_cnt_w-1:0] a,
        input logic [c_cnt_w-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : tone_edge_sync
// Brief    : Two-flop synchronizer plus history register; flags any edge of
//            the asynchronous input while enabled.
// Revision : 1.0 - initial release
// ============================================================================
module tone_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic async_in,
    output logic edge_pulse
);

    logic r_sync1_q, w_sync1_d;
    logic r_sync2_q, w_sync2_d;
    logic r_sync3_q, w_sync3_d;

    // The history flop freezes while disabled so an edge spanning the
    // disabled window is still reported on re-enable.
    always_comb begin
        w_sync1_d = async_in;
        w_sync2_d = r_sync1_q;
        w_sync3_d = enable ? r_sync2_q : r_sync3_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1_q <= 1'b0;
            r_sync2_q <= 1'b0;
            r_sync3_q <= 1'b0;
        end else begin
            r_sync1_q <= w_sync1_d;
            r_sync2_q <= w_sync2_d;
            r_sync3_q <= w_sync3_d;
        end
    end

    assign edge_pulse = enable & (r_sync2_q ^ r_sync3_q);

endmodule
`default_nettype wire

// File: rtl/tone_detect.sv
`default_nettype none
// ============================================================================
// Module   : tone_detect
// Brief    : Measures the half-period of a square-wave tone, locks when two
//            consecutive measurements agree within TOL, flags signal loss.
// Revision : 1.0 - initial release
// ============================================================================
module tone_detect
    import tone_detect_pkg::*;
#(
    parameter int TOL     = c_tol_default,
    parameter int TIMEOUT = c_timeout_default
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               tone_in,
    output logic [c_val_w-1:0] half_period,
    output logic               valid,
    output logic               locked,
    output logic               no_signal
);

    localparam logic [c_cnt_w-1:0] c_tol     = c_cnt_w'(TOL);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);

    logic                 w_edge;
    state_t               r_state_q, w_state_d;
    logic [c_cnt_w-1:0]   r_cnt_q, w_cnt_d;
    logic [c_cnt_w-1:0]   r_ref_q, w_ref_d;
    logic [c_val_w-1:0]   r_hp_q, w_hp_d;
    logic                 r_valid_q, w_valid_d;
    logic                 r_locked_q, w_locked_d;
    logic                 r_nosig_q, w_nosig_d;
    logic [c_cnt_w-1:0]   w_meas;
    logic                 w_match;
    logic                 w_timeout;

    tone_edge_sync u_edge_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .async_in   (tone_in),
        .edge_pulse (w_edge)
    );

    // Counter never drops below 1, so the subtraction cannot wrap.
    assign w_meas    = r_cnt_q - c_cnt_w'(1);
    assign w_match   = (abs_diff(w_meas, r_ref_q) <= c_tol);
    assign w_timeout = enable && !w_edge && (r_cnt_q >= c_timeout)
                       && (r_state_q != ST_IDLE);

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_ref_d   = r_ref_q;
        w_hp_d    = r_hp_q;
        w_valid_d = 1'b0;
        w_nosig_d = r_nosig_q;

        if (enable) begin
            if (w_edge) begin
                w_cnt_d = c_cnt_w'(1);
            end else if (r_cnt_q < c_timeout) begin
                w_cnt_d = r_cnt_q + c_cnt_w'(1);
            end

            if (w_edge) begin
                case (r_state_q)
                    ST_IDLE: begin
                        w_state_d = ST_FIRST;
                        w_nosig_d = 1'b0;
                    end
                    ST_FIRST: begin
                        w_ref_d   = w_meas;
                        w_state_d = ST_MEAS;
                    end
                    ST_MEAS: begin
                        if (w_match) begin
                            w_state_d = ST_LOCK;
                            w_hp_d    = w_meas[c_val_w-1:0];
                            w_valid_d = 1'b1;
                        end else begin
                            w_ref_d = w_meas;
                        end
                    end
                    ST_LOCK: begin
                        w_ref_d = w_meas;
                        if (w_match) begin
                            w_hp_d    = w_meas[c_val_w-1:0];
                            w_valid_d = 1'b1;
                        end else begin
                            w_state_d = ST_MEAS;
                        end
                    end
                    default: w_state_d = ST_IDLE;
                endcase
            end else if (w_timeout) begin
                w_state_d = ST_IDLE;
                w_nosig_d = 1'b1;
            end
        end

        w_locked_d = (w_state_d == ST_LOCK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q  <= ST_IDLE;
            r_cnt_q    <= c_cnt_w'(1);
            r_ref_q    <= '0;
            r_hp_q     <= '0;
            r_valid_q  <= 1'b0;
            r_locked_q <= 1'b0;
            r_nosig_q  <= 1'b1;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_ref_q    <= w_ref_d;
            r_hp_q     <= w_hp_d;
            r_valid_q  <= w_valid_d;
            r_locked_q <= w_locked_d;
            r_nosig_q  <= w_nosig_d;
        end
    end

    assign half_period = r_hp_q;
    assign valid       = r_valid_q;
    assign locked      = r_locked_q;
    assign no_signal   = r_nosig_q;

endmodule
`default_nettype wire

// File: tb/tb_tone_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_tone_detect
// Brief    : Directed bench for tone_detect with a half-period scoreboard;
//            a second instance with TOL=4 shares the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tone_detect;

    localparam int c_timeout = 1000;
    localparam int c_settle  = 5;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        enable  = 1'b0;
    logic        tone_in = 1'b0;
    logic [14:0] hp2, hp4;
    logic        v2, v4, l2, l4, n2, n4;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    logic        prev_v = 1'b0;

    always #5 clk = ~clk;

    tone_detect #(.TOL(2), .TIMEOUT(c_timeout)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tone_in(tone_in),
        .half_period(hp2), .valid(v2), .locked(l2), .no_signal(n2)
    );

    tone_detect #(.TOL(4), .TIMEOUT(c_timeout)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tone_in(tone_in),
        .half_period(hp4), .valid(v4), .locked(l4), .no_signal(n4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Toggle tone_in n rising edges after the previous toggle.
    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1 tone_in = ~tone_in;
    endtask

    // Consumes exactly c_settle rising edges, then parks on a falling edge.
    task automatic settle();
        repeat (c_settle) @(posedge clk);
        @(negedge clk);
    endtask

    // Every valid pulse pops one expected half_period; an unexpected pulse
    // compares against a value a 15-bit output can never take.
    always @(negedge clk) begin
        if (v2) begin
            chk("valid_one_cycle", 32'(prev_v), 32'd0);
            if (exp_q.size() == 0) mon_exp = 32'hFFFF_FFFF;
            else                   mon_exp = exp_q.pop_front();
            chk("half_period", 32'(hp2), mon_exp);
        end
        prev_v = v2;
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; tone_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_half_period", 32'(hp2), 32'd0);
        chk("rst_valid",       32'(v2),  32'd0);
        chk("rst_locked",      32'(l2),  32'd0);
        chk("rst_no_signal",   32'(n2),  32'd1);
        rst_n = 1'b1;

        // Lock near V=200; third interval differs by exactly TOL
        gap(10);
        settle();
        chk("first_edge_no_signal", 32'(n2), 32'd0);
        chk("first_edge_locked",    32'(l2), 32'd0);
        gap(201 - c_settle);
        settle();
        chk("second_edge_locked", 32'(l2), 32'd0);
        exp_q.push_back(32'd202);
        gap(203 - c_settle);
        settle();
        chk("lock_at_tol", 32'(l2), 32'd1);
        exp_q.push_back(32'd200);
        gap(201 - c_settle);
        settle();
        chk("lock_hold", 32'(l2), 32'd1);

        // Frequency step to V=280
        gap(281 - c_settle);
        settle();
        chk("step_unlock",   32'(l2),  32'd0);
        chk("step_hp_hold",  32'(hp2), 32'd200);
        exp_q.push_back(32'd280);
        gap(281 - c_settle);
        settle();
        chk("step_relock", 32'(l2), 32'd1);

        // 1000 disabled cycles inside an interval
        repeat (50 - c_settle) @(posedge clk);
        #1 enable = 1'b0;
        repeat (500) @(posedge clk);
        @(negedge clk);
        chk("disabled_valid",  32'(v2), 32'd0);
        chk("disabled_locked", 32'(l2), 32'd1);
        repeat (500) @(posedge clk);
        #1 enable = 1'b1;
        exp_q.push_back(32'd280);
        gap(231);
        settle();
        chk("no_false_timeout", 32'(n2), 32'd0);
        chk("enable_locked",    32'(l2), 32'd1);

        // Loss of signal
        repeat (990 - c_settle) @(posedge clk);
        @(negedge clk);
        chk("pre_timeout_no_signal", 32'(n2), 32'd0);
        chk("pre_timeout_locked",    32'(l2), 32'd1);
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("timeout_no_signal", 32'(n2),  32'd1);
        chk("timeout_locked",    32'(l2),  32'd0);
        chk("timeout_hp_hold",   32'(hp2), 32'd280);

        // Recovery from IDLE needs three edges again
        gap(10);
        settle();
        chk("recover_no_signal", 32'(n2), 32'd0);
        chk("recover_locked",    32'(l2), 32'd0);
        gap(281 - c_settle);
        settle();
        chk("recover_second_edge", 32'(l2), 32'd0);
        exp_q.push_back(32'd280);
        gap(281 - c_settle);
        settle();
        chk("recover_lock", 32'(l2), 32'd1);

        // Asynchronous reset between edges while locked
        repeat (100) @(posedge clk);
        #3 rst_n = 1'b0;
        tone_in = 1'b0;
        #1;
        chk("async_rst_half_period", 32'(hp2), 32'd0);
        chk("async_rst_valid",       32'(v2),  32'd0);
        chk("async_rst_locked",      32'(l2),  32'd0);
        chk("async_rst_no_signal",   32'(n2),  32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        gap(50);
        settle();
        gap(281 - c_settle);
        settle();
        chk("post_rst_two_edges", 32'(l2), 32'd0);
        exp_q.push_back(32'd280);
        gap(281 - c_settle);
        settle();
        chk("post_rst_lock", 32'(l2), 32'd1);

        // Jitter of +/-2 around V=200: difference 4 between intervals
        rst_n = 1'b0;
        tone_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        gap(20);
        for (int i = 0; i < 6; i++) begin
            gap((i % 2 == 0) ? 203 : 199);
        end
        settle();
        chk("jitter_tol2_locked", 32'(l2),  32'd0);
        chk("jitter_tol2_hp",     32'(hp2), 32'd0);
        chk("jitter_tol4_locked", 32'(l4),  32'd1);
        chk("jitter_tol4_hp",     32'(hp4), 32'd198);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
